// File: rtl/ppu_pkg.sv
// Shared PPU sprite-stage types and constants.
package ppu_pkg;

  localparam int unsigned NUM_SPRITE_SLOTS = 8;
  localparam int unsigned SPRITE_PIXEL_W   = 5;
  localparam int unsigned SLOT_IDX_W       = 3;
  localparam int unsigned X_W              = 8;
  localparam int unsigned PAT_W            = 8;
  localparam int unsigned PAL_W            = 2;

  // OAM attribute byte bit positions
  localparam int unsigned ATTR_HFLIP = 6;
  localparam int unsigned ATTR_PRIO  = 5;

  // One sprite pixel as seen by the combiner; prio = 1 means behind BG.
  typedef struct packed {
    logic             prio;
    logic [PAL_W-1:0] palette;
    logic [1:0]       pattern;
  } sprite_pixel_t;

  // Mirror a pattern byte so hflip costs nothing at shift time.
  function automatic logic [PAT_W-1:0] bit_rev(input logic [PAT_W-1:0] b);
    logic [PAT_W-1:0] r;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      r[i] = b[PAT_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: staging bank, X down-counter, pattern shifters, pixel mux.
module sprite_slot
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en_i,
  input  logic [X_W-1:0]   load_x_i,
  input  logic             load_hflip_i,
  input  logic             load_prio_i,
  input  logic [PAL_W-1:0] load_pal_i,
  input  logic [PAT_W-1:0] load_lo_i,
  input  logic [PAT_W-1:0] load_hi_i,
  input  logic             line_start_i,
  input  logic             pixel_en_i,
  output sprite_pixel_t    pixel_o
);

  logic [X_W-1:0]   stg_x_q,   stg_x_d;
  logic             stg_prio_q, stg_prio_d;
  logic [PAL_W-1:0] stg_pal_q, stg_pal_d;
  logic [PAT_W-1:0] stg_lo_q,  stg_lo_d;
  logic [PAT_W-1:0] stg_hi_q,  stg_hi_d;

  logic [X_W-1:0]   cnt_q,  cnt_d;
  logic             prio_q, prio_d;
  logic [PAL_W-1:0] pal_q,  pal_d;
  logic [PAT_W-1:0] lo_q,   lo_d;
  logic [PAT_W-1:0] hi_q,   hi_d;

  // Staging: cleared by commit, then a same-cycle load lands on top.
  always_comb begin
    stg_x_d    = stg_x_q;
    stg_prio_d = stg_prio_q;
    stg_pal_d  = stg_pal_q;
    stg_lo_d   = stg_lo_q;
    stg_hi_d   = stg_hi_q;
    if (line_start_i) begin
      stg_x_d  = '0;
      stg_lo_d = '0;
      stg_hi_d = '0;
    end
    if (load_en_i) begin
      stg_x_d    = load_x_i;
      stg_prio_d = load_prio_i;
      stg_pal_d  = load_pal_i;
      stg_lo_d   = load_hflip_i ? bit_rev(load_lo_i) : load_lo_i;
      stg_hi_d   = load_hflip_i ? bit_rev(load_hi_i) : load_hi_i;
    end
  end

  // Active: commit has priority over advance; counter first, then shifters.
  always_comb begin
    cnt_d  = cnt_q;
    prio_d = prio_q;
    pal_d  = pal_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (line_start_i) begin
      cnt_d  = stg_x_q;
      prio_d = stg_prio_q;
      pal_d  = stg_pal_q;
      lo_d   = stg_lo_q;
      hi_d   = stg_hi_q;
    end else if (pixel_en_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - X_W'(1);
      end else begin
        lo_d = {lo_q[PAT_W-2:0], 1'b0};
        hi_d = {hi_q[PAT_W-2:0], 1'b0};
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_x_q    <= '0;
      stg_prio_q <= 1'b0;
      stg_pal_q  <= '0;
      stg_lo_q   <= '0;
      stg_hi_q   <= '0;
      cnt_q      <= '0;
      prio_q     <= 1'b0;
      pal_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      stg_x_q    <= stg_x_d;
      stg_prio_q <= stg_prio_d;
      stg_pal_q  <= stg_pal_d;
      stg_lo_q   <= stg_lo_d;
      stg_hi_q   <= stg_hi_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      pal_q      <= pal_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
    end
  end

  // Zero-latency pixel: pattern shows only once the counter has run out.
  always_comb begin
    pixel_o.prio    = prio_q;
    pixel_o.palette = pal_q;
    pixel_o.pattern = (cnt_q == '0) ? {hi_q[PAT_W-1], lo_q[PAT_W-1]} : 2'b00;
  end

endmodule

// File: rtl/sprite_slot_bank.sv
// Per-line sprite output stage: load decode, slot array and sprite-0 flag.
module sprite_slot_bank
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SPRITE_SLOTS
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      load_en,
  input  logic [SLOT_IDX_W-1:0]                     load_slot,
  input  logic [X_W-1:0]                            load_x,
  input  logic [7:0]                                load_attr,
  input  logic [PAT_W-1:0]                          load_pat_lo,
  input  logic [PAT_W-1:0]                          load_pat_hi,
  input  logic                                      load_is_sp0,
  input  logic                                      line_start,
  input  logic                                      pixel_en,
  output logic [NUM_SLOTS-1:0][SPRITE_PIXEL_W-1:0]  sprites,
  output logic                                      is_sprite0
);

  logic stg_sp0_q, stg_sp0_d;
  logic sp0_q, sp0_d;
  logic sp0_we_c;
  logic unused_attr_c;

  assign unused_attr_c = ^{load_attr[7], load_attr[4:2]};

  // Slot array; an index with no matching slot writes nothing.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    sprite_pixel_t pix;
    sprite_slot u_slot (
      .clk          (clk),
      .rst_n        (reset_n),
      .load_en_i    (load_en && (load_slot == SLOT_IDX_W'(i))),
      .load_x_i     (load_x),
      .load_hflip_i (load_attr[ATTR_HFLIP]),
      .load_prio_i  (load_attr[ATTR_PRIO]),
      .load_pal_i   (load_attr[PAL_W-1:0]),
      .load_lo_i    (load_pat_lo),
      .load_hi_i    (load_pat_hi),
      .line_start_i (line_start),
      .pixel_en_i   (pixel_en),
      .pixel_o      (pix)
    );
    assign sprites[i] = pix;
  end

  assign sp0_we_c = load_en && (load_slot == '0);

  // Sprite-0 flag follows slot 0's staging/commit rules.
  always_comb begin
    stg_sp0_d = stg_sp0_q;
    sp0_d     = sp0_q;
    if (line_start) begin
      sp0_d     = stg_sp0_q;
      stg_sp0_d = 1'b0;
    end
    if (sp0_we_c) begin
      stg_sp0_d = load_is_sp0;
    end
  end

  // Sprite-0 flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_sp0_q <= 1'b0;
      sp0_q     <= 1'b0;
    end else begin
      stg_sp0_q <= stg_sp0_d;
      sp0_q     <= sp0_d;
    end
  end

  assign is_sprite0 = sp0_q;

endmodule

// File: doc/sprite_slot_bank.md
# sprite_slot_bank

Per-line sprite output stage of the PPU. Holds up to eight sprites fetched for the next scanline, commits them at line start, and drives the `sprites[7:0]` / `is_sprite0` inputs of the pixel combiner one dot at a time. Each slot runs an X down-counter followed by a 2-bit pattern shifter, so the combiner sees each sprite's pixel at the correct screen X.

## Interface

- `NUM_SLOTS`, default 8: number of sprite slots, which is the per-line sprite limit.

- `clk`  in  1  PPU dot clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `load_en`  in  1  writes one slot's staging registers this cycle.
- `load_slot`  in  3  target slot index.
- `load_x`  in  8  sprite X position.
- `load_attr`  in  8  OAM attribute byte:
  - bit6 = hflip;
  - bit5 = priority, where 1 means behind BG;
  - bits1:0 = palette.
- `load_pat_lo`, `load_pat_hi`  in  8 each  pattern bitplanes, with vflip already applied by the fetcher.
- `load_is_sp0`  in  1  the sprite being loaded is OAM sprite 0. Honoured only when `load_slot == 0`.
- `line_start`  in  1  one-cycle pulse at the first visible dot. Commits staging to active.
- `pixel_en`  in  1  one pulse per visible dot.
- `sprites[NUM_SLOTS-1:0]`  out  5 each  per-slot pixel `{priority, palette[1:0], pattern[1:0]}`. Pattern 00 = transparent.
- `is_sprite0`  out  1  active slot 0 holds OAM sprite 0.

## Operation

- **Staging bank (per slot)**
  - Fields: x, priority, palette, pat_lo, pat_hi, plus an sp0 flag on slot 0 only.
  - `load_en` writes the staging bank of the addressed slot.
  - hflip is resolved at load time: bit-reversed pattern bytes are stored.
  - Out-of-range `load_slot` (≥ `NUM_SLOTS`) is ignored.
- **Commit on `line_start`**
  - Every slot copies its staging values into its active registers: counter ← x, shifters ← patterns, prio/pal latched.
  - `is_sprite0` ← staged sp0 flag.
  - All staging then clears to x = 0, patterns = 0, sp0 = 0. A slot that is not reloaded before the next commit is therefore transparent.
- **Advance on `pixel_en`** (without `line_start`), per slot:
  - counter ≠ 0: decrement the counter; output pattern = 00.
  - counter == 0: output pattern = `{hi[7], lo[7]}`, then shift both shifters left and fill with 0.
  - After 8 shifts the slot is transparent for the rest of the line.
- **Output formation**
  - `sprites[i]` is combinational from the active registers: `{prio, pal, (cnt==0) ? {hi[7], lo[7]} : 2'b00}`.
  - When the pattern is 00, prio and pal are still driven, but the combiner treats the slot as transparent.
- **Simultaneous events**
  - `line_start` and `pixel_en` together: the commit wins; there is no advance that cycle.
  - `load_en` and `line_start` together:
    - the commit uses the pre-edge staging values;
    - the load lands in the freshly cleared staging and applies to the next line.
  - Two loads to the same slot: last write wins.
- **Idle**: with no `pixel_en`, all state holds.

## Timing

- **Reset**: all active and staging registers are 0. All `sprites[i]` = 5'b00000 and `is_sprite0` = 0, immediately and asynchronously.
- **Pixel latency**: 0 cycles from state to output. The value present during a `pixel_en` cycle is that dot's pixel, and state updates at that edge.
- **Dot numbering**: the dot counted from 0 after commit. A sprite at X = n shows pattern bit 7 on dot n and bit 0 on dot n+7.
- **X near the right edge**: at X = 255 only dot 255 shows within a 256-dot line. No wrap into the next line, because the commit reloads the slot.
- **Reset mid-line**: all outputs return to 0. Nothing appears until the next load + commit.

## Structure

- **`ppu_pkg` contents**:
  - `NUM_SPRITE_SLOTS` = 8;
  - `SPRITE_PIXEL_W` = 5;
  - `sprite_pixel_t` packed struct `{logic priority; logic [1:0] palette; logic [1:0] pattern;}`;
  - bit-position constants for the attribute byte (HFLIP = 6, PRIO = 5).
- **Sub-module `sprite_slot`**: one slot containing staging, counter, shifters and the output mux. It is instantiated `NUM_SLOTS` times in a generate loop. Slot 0 additionally carries the sp0 staging/active flag, in the top level.
- The top level holds only load decode and the `is_sprite0` flag.

## Test plan

- **Basic placement**: load slot 0 with x = 10, lo = 0x80, hi = 0x00, pal = 2, prio = 0; `line_start`; 20 × `pixel_en` → `sprites[0]` = 5'b0_10_01 on dot 10 only, 5'b0_10_00 on every other dot.
- **Full bytes and hflip**:
  - x = 0, lo = hi = 0xFF, prio = 1 → pattern 11 on dots 0–7, 00 on dot 8.
  - Then hflip = 1 with lo = 0x01 → pattern 01 on dot 0 only.
- **Staging clear and sprite 0**:
  - Load slot 3 and slot 0 with `load_is_sp0` = 1; commit → `is_sprite0` = 1.
  - Next line with no loads → slot 3 is transparent all line and `is_sprite0` = 0.
- **Simultaneous load and commit**: `load_en` (slot 1, x = 4, lo = 0xFF) in the same cycle as `line_start` → slot 1 is transparent this line and shows on dots 4–11 of the following line.
- **Right edge**: x = 255, lo = 0xFF, 256 dots → pattern 01 on dot 255 only. `line_start` together with `pixel_en` → counters reload with no decrement.
- **Mid-line reset**: `reset_n` low on dot 12 of a busy line → all `sprites` = 0 and `is_sprite0` = 0 asynchronously, and they stay 0 through following `pixel_en` until a new load + commit.
